// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core pipeline stages.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage and imem.
interface fetch_stage_if;
    logic        IReq;
    logic [31:0] IAddr;
    logic [31:0] IRData;
    logic        IReady;

    modport master (output IReq, output IAddr, input IRData, input IReady);
    modport slave  (input IReq, input IAddr, output IRData, output IReady);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and imem handshake.
// Optional JUMP_EN adds the JumpD/PCJumpD redirect source (jump beats branch).
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
`ifdef JUMP_EN
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
`endif
    fetch_stage_if.master imem,
    output logic [31:0] InstrF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF,
    output logic [31:0] PCF
);

    fetch_state_e state_q, state_n;
    logic [31:0]  pc_q, pc_n;
    logic [31:0]  hold_q, hold_n;
    logic [31:0]  redir_q, redir_n;
    logic         redirect;
    logic [31:0]  target_raw;
    logic [31:0]  target;

    // Redirect source selection; a stalled decode cannot redirect.
`ifdef JUMP_EN
    assign redirect   = !StallF && (PCSrcD || JumpD);
    assign target_raw = JumpD ? PCJumpD : PCBranchD;
`else
    assign redirect   = !StallF && PCSrcD;
    assign target_raw = PCBranchD;
`endif
    assign target = {target_raw[31:2], 2'b00};

    assign PCF      = pc_q;
    assign PCPlus4F = pc_q + 32'd4;

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            hold_q  <= NOP_INSTR;
            redir_q <= 32'h0000_0000;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            hold_q  <= hold_n;
            redir_q <= redir_n;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        hold_n  = hold_q;
        redir_n = redir_q;
        unique case (state_q)
            IDLE: state_n = FETCH;
            FETCH: begin
                if (imem.IReady) begin
                    if (redirect) begin
                        pc_n = target;
                    end else if (!StallF) begin
                        pc_n = PCPlus4F;
                    end else begin
                        hold_n  = imem.IRData;
                        state_n = HOLD;
                    end
                end else if (redirect) begin
                    // Address must stay stable until imem completes, so park the target.
                    redir_n = target;
                    state_n = FLUSH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_n    = target;
                    state_n = FETCH;
                end else if (!StallF) begin
                    pc_n    = PCPlus4F;
                    state_n = FETCH;
                end
            end
            FLUSH: begin
                if (redirect) redir_n = target;
                if (imem.IReady) begin
                    // A redirect landing with the completion is the newest target.
                    pc_n    = redirect ? target : redir_q;
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from state; InstrF bypasses IRData for zero-wait fetch.
    always_comb begin
        imem.IReq  = 1'b0;
        imem.IAddr = pc_q;
        ValidF     = 1'b0;
        InstrF     = NOP_INSTR;
        unique case (state_q)
            IDLE: ;
            FETCH: begin
                imem.IReq = 1'b1;
                if (imem.IReady) begin
                    ValidF = 1'b1;
                    InstrF = imem.IRData;
                end
            end
            HOLD: begin
                ValidF = 1'b1;
                InstrF = hold_q;
            end
            FLUSH: imem.IReq = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It sits directly upstream of the IF/ID pipeline register. It owns the PC register and next-PC selection, and drives a request/ready handshake to instruction memory. Each cycle it presents InstrF, PCPlus4F and ValidF to the IF/ID register. It absorbs memory wait states, stalls from the hazard unit and branch/jump redirects from decode.

## Interface
- RESET_PC, default 32'h0000_0000, PC value loaded on reset.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- StallF  in  1  hazard-unit stall; holds the PC.
- PCSrcD  in  1  branch taken in decode.
- PCBranchD  in  32  branch target.
- JumpD  in  1  jump in decode (JUMP_EN only).
- PCJumpD  in  32  jump target (JUMP_EN only).
- IReq  out  1  instruction-memory request.
- IAddr  out  32  fetch address (= PCF).
- IRData  in  32  instruction-memory read data, valid when IReady.
- IReady  in  1  memory completes the request this cycle; zero-wait allowed.
- InstrF  out  32  fetched instruction; 0 (NOP) when !ValidF.
- PCPlus4F  out  32  PCF + 4.
- ValidF  out  1  InstrF is a real instruction. The hazard unit drives the IF/ID CLR from !ValidF.
- PCF  out  32  current PC, for debug.

## Operation
- Redirect condition: redirect = !StallF && (PCSrcD || JumpD). Target: JumpD ? PCJumpD : PCBranchD, so a jump wins over a branch. Redirects are ignored while StallF=1.
- PCPlus4F = PCF + 4, modulo 2^32. PCF bits [1:0] are always 0. The 32'hFFFF_FFFC + 4 → 0 wrap is legal.
- State IDLE (reset state):
  - IReq=0, ValidF=0.
  - Next cycle goes to FETCH unconditionally.
- State FETCH:
  - IReq=1, IAddr=PCF.
  - IReady=0: ValidF=0. On redirect, latch the target into RedirPC and go to FLUSH; PCF is unchanged.
  - IReady=1: ValidF=1, InstrF=IRData. The next step depends on redirect and StallF:
    - Redirect: PCF ← target, stay in FETCH. The fetched word is still presented this cycle; decode squashes it.
    - No redirect, !StallF: PCF ← PCPlus4F.
    - No redirect, StallF=1: HoldBuf ← IRData, go to HOLD.
- State HOLD:
  - IReq=0, ValidF=1, InstrF=HoldBuf.
  - Redirect: PCF ← target, go to FETCH, HoldBuf discarded.
  - Else if !StallF: PCF ← PCPlus4F, go to FETCH.
- State FLUSH:
  - IReq=1, IAddr=old PCF. The address is held stable until the memory completes.
  - ValidF=0; the returning data is discarded.
  - On IReady: PCF ← RedirPC, go to FETCH.
  - A further redirect in FLUSH overwrites RedirPC.
- Handshake rule: once IReq is raised, IAddr must not change until IReady is seen. The only exception is reset.

## Timing
- Reset values: PCF=RESET_PC, state=IDLE, IReq=0, ValidF=0, InstrF=0, HoldBuf=0, RedirPC=0. PCPlus4F = RESET_PC+4.
- Reset asserted mid-request drops IReq immediately. The instruction memory treats a dropped request as abandoned.
- First IReq is asserted in the second cycle after RST deasserts.
- With a zero-wait memory and no stalls: one instruction per cycle, and InstrF is combinational from IRData in the same cycle.
- Each memory wait cycle yields one ValidF=0 bubble.
- Redirect while waiting costs the remaining wait cycles + 1 before the target request issues.

## Configuration
- JUMP_EN defined:
  - JumpD and PCJumpD ports exist.
  - Jump takes priority over branch in target selection.
- JUMP_EN undefined:
  - JumpD and PCJumpD ports are absent.
  - Redirect = !StallF && PCSrcD, target = PCBranchD.

## Structure
- Shared package `mips_pkg` holds:
  - the fetch state typedef (IDLE, FETCH, HOLD, FLUSH);
  - the NOP constant 32'h0000_0000;
  - the default RESET_PC.
- No sub-module. The PC register, HoldBuf and FSM stay in one module; next-PC selection is one combinational block.

## Test plan
- Zero-wait memory, no stalls, RESET_PC=0: IAddr runs 0, 4, 8, C on consecutive cycles, ValidF=1 each cycle, InstrF equals the memory words.
- IReady low for 2 cycles at PC=8: two ValidF=0/InstrF=0 cycles, IAddr stays 8, then the word at 8 with ValidF=1.
- StallF=1 for 3 cycles coinciding with the IReady of PC=C:
  - enters HOLD with InstrF stable;
  - IReq=0 during the stall;
  - PC=10 is requested the cycle after StallF falls.
- PCSrcD=1, PCBranchD=40 while PC=14 is waiting:
  - IAddr holds 14 until IReady;
  - that data is dropped with ValidF=0;
  - the next request is to 40.
- JUMP_EN with JumpD=1/PCJumpD=100 and PCSrcD=1/PCBranchD=40 in the same cycle: next fetch address is 100. Repeat with StallF=1: no redirect occurs.
- RST dropped while in FLUSH: IReq=0, ValidF=0 and PCF=RESET_PC immediately. Resumes from IDLE after release.
